// File: rtl/count_event_capture_pkg.sv
// Shared definitions for the event-capture block: register map, bit positions
// and FIFO entry layout.
package count_event_capture_pkg;

  localparam int unsigned CHAN_W  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ENTRY_W = CHAN_W + CNT_W;

  localparam logic [CNT_W-1:0] CMP_RST = 16'hFFFF;

  // Register select from wbs_adr_i[3:2]
  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_STAT = 2'd1,
    REG_FIFO = 2'd2,
    REG_CMP  = 2'd3
  } reg_sel_e;

  // CTRL fields
  localparam int unsigned CTRL_W        = 5;
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_EDGE     = 1;
  localparam int unsigned CTRL_MASK_LSB = 2;

  // STAT fields
  localparam int unsigned STAT_EMPTY = 8;
  localparam int unsigned STAT_FULL  = 9;
  localparam int unsigned STAT_OVF   = 16;
  localparam int unsigned STAT_MISS  = 17;
  localparam int unsigned STAT_HIT   = 18;

  // FIFO read word
  localparam int unsigned FIFO_VALID = 31;

endpackage

// File: rtl/count_event_capture_fifo.sv
// Synchronous capture FIFO. A push while full is accepted only when a pop
// happens on the same cycle; pops on an empty FIFO are ignored.
module capture_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array, written at the tail
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/count_event_capture.sv
// Event timestamp capture: synchronises event inputs, captures {chan,count}
// into a FIFO, flags compare matches and exposes everything over Wishbone.
module count_event_capture
  import count_event_capture_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [15:0]      count_i,
  input  logic [NCH-1:0]   evt_i,
  output logic [2:0]       irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic              ack_q;
  logic [31:0]       dat_q;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic              ovf_q, ovf_d, miss_q, miss_d, hit_q, hit_d;
  logic              eq_q;
  logic [2:0]        irq_q;
  logic [NCH-1:0]    s1_q, s2_q, hist_q, edge_v;
  logic              req_q, req_d, multi_q, multi_d;
  logic [CHAN_W-1:0] chan_q, chan_d;

  logic              acc, wr, rd, w1c, pop, push, ovf_set, cmp_eq;
  reg_sel_e          rsel;
  logic [31:0]       rdata, lvl32;
  logic [3:0]        lvl_sat;
  logic [ENTRY_W-1:0] head;
  logic              full, empty;
  logic [LW-1:0]     level;
  logic              unused_bits;

  // Access is taken on the cycle ack gets set, so side effects happen once
  assign acc  = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign rsel = reg_sel_e'(wbs_adr_i[3:2]);
  assign wr   = acc & wbs_we_i;
  assign rd   = acc & ~wbs_we_i;
  assign w1c  = wr & (rsel == REG_STAT) & wbs_sel_i[2];
  assign pop  = rd & (rsel == REG_FIFO) & ~empty;

  assign push    = req_q & (~full | pop);
  assign ovf_set = req_q & full & ~pop;
  assign cmp_eq  = (count_i == cmp_q);

  assign lvl32   = 32'(level);
  assign lvl_sat = (lvl32 > 32'd15) ? 4'hF : lvl32[3:0];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:19],
                         wbs_sel_i[3], lvl32[31:4]};

  capture_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({chan_q, count_i}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Edge detect on the synchronised inputs, then lowest-index priority pick
  always_comb begin
    edge_v  = ctrl_q[CTRL_EDGE] ? (~s2_q & hist_q) : (s2_q & ~hist_q);
    if (!ctrl_q[CTRL_EN]) edge_v = '0;
    req_d   = 1'b0;
    multi_d = 1'b0;
    chan_d  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (edge_v[i]) begin
        if (req_d) multi_d = 1'b1;
        else begin
          req_d  = 1'b1;
          chan_d = CHAN_W'(i);
        end
      end
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (rsel)
      REG_CTRL: rdata[CTRL_W-1:0] = ctrl_q;
      REG_STAT: begin
        rdata[3:0]        = lvl_sat;
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_OVF]   = ovf_q;
        rdata[STAT_MISS]  = miss_q;
        rdata[STAT_HIT]   = hit_q;
      end
      REG_FIFO: if (!empty) begin
        rdata[FIFO_VALID]    = 1'b1;
        rdata[ENTRY_W-1:0]   = head;
      end
      REG_CMP:  rdata[CNT_W-1:0] = cmp_q;
      default:  rdata = '0;
    endcase
  end

  // Register writes and sticky flags; a new set beats a same-cycle W1C
  always_comb begin
    ctrl_d = ctrl_q;
    cmp_d  = cmp_q;
    ovf_d  = ovf_q;
    miss_d = miss_q;
    hit_d  = hit_q;
    if (wr && rsel == REG_CTRL && wbs_sel_i[0]) ctrl_d = wbs_dat_i[CTRL_W-1:0];
    if (wr && rsel == REG_CMP) begin
      if (wbs_sel_i[0]) cmp_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) cmp_d[15:8] = wbs_dat_i[15:8];
    end
    if (w1c) begin
      if (wbs_dat_i[STAT_OVF])  ovf_d  = 1'b0;
      if (wbs_dat_i[STAT_MISS]) miss_d = 1'b0;
      if (wbs_dat_i[STAT_HIT])  hit_d  = 1'b0;
    end
    if (ovf_set)            ovf_d  = 1'b1;
    if (req_q && multi_q)   miss_d = 1'b1;
    if (cmp_eq && !eq_q)    hit_d  = 1'b1;
  end

  // State registers: WB response, config, flags, sync chain, capture request
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ctrl_q  <= '0;
      cmp_q   <= CMP_RST;
      ovf_q   <= 1'b0;
      miss_q  <= 1'b0;
      hit_q   <= 1'b0;
      eq_q    <= 1'b0;
      irq_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      hist_q  <= '0;
      req_q   <= 1'b0;
      multi_q <= 1'b0;
      chan_q  <= '0;
    end else begin
      ack_q   <= acc;
      dat_q   <= rd ? rdata : '0;
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      ovf_q   <= ovf_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
      eq_q    <= cmp_eq;
      irq_q   <= {hit_q, ovf_q, ~empty} & ctrl_q[CTRL_MASK_LSB +: 3];
      s1_q    <= evt_i;
      s2_q    <= s1_q;
      hist_q  <= s2_q;
      req_q   <= req_d;
      multi_q <= multi_d;
      chan_q  <= chan_d;
    end
  end

endmodule

// File: tb/tb_count_event_capture.sv
// Directed bench for count_event_capture with hand-computed expectations.
module tb_count_event_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] count_i = '0;
  logic [3:0]  evt_i = '0;
  logic [2:0]  irq;
  logic        cnt_run = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  count_event_capture #(.NCH(4), .DEPTH(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .count_i    (count_i),
    .evt_i      (evt_i),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_run) count_i = count_i + 16'd1;
  endtask

  task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
    int unsigned n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; wdat = d; sel = s;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 8);
    chk("wb_ack_lat", n, 1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] q);
    wb_access(1'b0, a, '0, 4'hF, q);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_access(1'b1, a, d, s, q);
  endtask

  task automatic evt_pulse(input logic [3:0] m, input logic [15:0] c);
    count_i = c;
    evt_i = m;
    repeat (4) tick();
    evt_i = '0;
    repeat (3) tick();
  endtask

  initial begin
    logic [31:0] v;
    int unsigned n;

    // 1: reset state
    repeat (3) tick();
    chk("irq_in_reset", {29'd0, irq}, 32'h0);
    rst_n = 1'b1;
    tick();
    wb_read(2'd1, v); chk("stat_rst", v, 32'h0000_0100);
    wb_read(2'd3, v); chk("cmp_rst", v, 32'h0000_FFFF);
    wb_read(2'd0, v); chk("ctrl_rst", v, 32'h0000_0000);
    chk("irq_rst", {29'd0, irq}, 32'h0);

    // 2: single rising capture with a running counter
    wb_write(2'd0, 32'h05, 4'h1);
    count_i = 16'h1234;
    evt_i = 4'b0100;
    cnt_run = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq[0] && n < 8);
    chk("irq0_rise", {31'd0, irq[0]}, 32'h1);
    chk("irq0_lat", n, 5);
    cnt_run = 1'b0;
    evt_i = '0;
    repeat (3) tick();
    wb_read(2'd2, v); chk("fifo_first", v, 32'h8002_1237);
    wb_read(2'd2, v); chk("fifo_empty_read", v, 32'h0);
    wb_read(2'd1, v); chk("stat_after_pop", v, 32'h0000_0100);
    chk("irq0_clear", {29'd0, irq}, 32'h0);

    // 3: overflow after nine captures, then drain in order
    for (int k = 0; k < 9; k++) evt_pulse(4'b0001, 16'h0100 + 16'(k));
    wb_read(2'd1, v); chk("stat_full_ovf", v, 32'h0001_0208);
    wb_write(2'd1, 32'h0001_0000, 4'h4);
    wb_read(2'd1, v); chk("stat_ovf_w1c", v, 32'h0000_0208);
    for (int k = 0; k < 8; k++) begin
      wb_read(2'd2, v);
      chk("fifo_drain", v, 32'h8000_0100 + 32'(k));
    end
    wb_read(2'd1, v); chk("stat_drained", v, 32'h0000_0100);

    // 4: simultaneous edges -> lowest channel wins, miss set
    evt_pulse(4'b1010, 16'h0555);
    wb_read(2'd2, v); chk("fifo_prio", v, 32'h8001_0555);
    wb_read(2'd2, v); chk("fifo_prio_single", v, 32'h0);
    wb_read(2'd1, v); chk("stat_miss", v, 32'h0002_0100);
    wb_write(2'd1, 32'h0002_0000, 4'h4);
    wb_read(2'd1, v); chk("stat_miss_w1c", v, 32'h0000_0100);

    // 5: compare hit, held value does not re-set after clear
    wb_write(2'd3, 32'h0000_0040, 4'h3);
    wb_read(2'd3, v); chk("cmp_write", v, 32'h0000_0040);
    wb_write(2'd0, 32'h10, 4'h1);
    count_i = 16'h003E; tick();
    count_i = 16'h003F; tick();
    count_i = 16'h0040; tick();
    count_i = 16'h0041; tick();
    chk("irq2_hit", {29'd0, irq}, 32'h4);
    wb_read(2'd1, v); chk("stat_hit", v, 32'h0004_0100);
    count_i = 16'h0040; tick();
    wb_write(2'd1, 32'h0004_0000, 4'h4);
    tick();
    wb_read(2'd1, v); chk("stat_hit_hold", v, 32'h0000_0100);
    chk("irq2_clear", {29'd0, irq}, 32'h0);

    // 6: pop coincident with a push into a full FIFO
    count_i = 16'h0000;
    wb_write(2'd0, 32'h05, 4'h1);
    for (int k = 0; k < 8; k++) evt_pulse(4'b0001, 16'h0200 + 16'(k));
    wb_read(2'd1, v); chk("stat_full", v, 32'h0000_0208);
    count_i = 16'h0300;
    evt_i = 4'b0001;
    repeat (3) tick();
    wb_read(2'd2, v); chk("fifo_pop_push", v, 32'h8000_0200);
    evt_i = '0;
    repeat (3) tick();
    wb_read(2'd1, v); chk("stat_no_ovf", v, 32'h0000_0208);
    for (int k = 1; k < 8; k++) begin
      wb_read(2'd2, v);
      chk("fifo_drain2", v, 32'h8000_0200 + 32'(k));
    end
    wb_read(2'd2, v); chk("fifo_last", v, 32'h8000_0300);
    wb_read(2'd1, v); chk("stat_final", v, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
